// File: rtl/cpu_uart_pkg.sv
// cpu_uart_pkg: shared types and constants for the cpu_uart bus responder.
// Holds the register index enum, STATUS bit positions, the TX/RX FSM state
// enums and the effective-divider helper.
package cpu_uart_pkg;

   typedef enum logic [1:0] {
      R_STATUS = 2'd0,
      R_DATA   = 2'd1,
      R_BAUD   = 2'd2
   } reg_idx_t;

   localparam int ST_TX_BUSY      = 0;
   localparam int ST_TX_FULL      = 1;
   localparam int ST_RX_VALID     = 2;
   localparam int ST_RX_OVERRUN   = 3;
   localparam int ST_TX_DROP      = 4;
   localparam int ST_RX_FRAME_ERR = 5;
   localparam int ST_LOOPBACK     = 8;

   typedef enum logic [1:0] {
      T_IDLE,
      T_START,
      T_DATA,
      T_STOP
   } tx_state_t;

   // RX_ prefix keeps these apart from the register index names
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // dividers below 2 would leave no room for a mid-bit sample
   function automatic logic [15:0] eff_baud(input logic [15:0] b);
      return (b < 16'd2) ? 16'd2 : b;
   endfunction

endpackage

// File: rtl/cpu_uart_rx.sv
// cpu_uart_rx: 8N1 receiver with 2-flop synchroniser, start-bit glitch filter
// and bit sampler.
// Ports: i_clk, i_reset (async, active high), i_rxd (asynchronous line),
//        i_baud (effective clocks per bit, >= 2), o_rx_strobe (1-cycle pulse
//        with a good byte), o_rx_data (byte, valid with the strobe),
//        o_frame_err (1-cycle pulse when the stop bit reads 0).
module cpu_uart_rx
   import cpu_uart_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_rxd,
   input  logic [15:0] i_baud,
   output logic        o_rx_strobe,
   output logic [7:0]  o_rx_data,
   output logic        o_frame_err
);

   rx_state_t   r_state, w_next;
   logic [1:0]  r_sync;
   logic        r_prev;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_strobe;
   logic [7:0]  r_data;
   logic        r_frame_err;
   logic        w_rx, w_fall, w_end, w_stop_end;

   assign w_rx       = r_sync[1];
   assign w_fall     = r_prev & ~w_rx;
   assign w_end      = (r_cnt == 16'd0);
   assign w_stop_end = (r_state == RX_STOP) && w_end;

   always_comb begin
      w_next = r_state;
      case (r_state)
         RX_IDLE:  if (w_fall) w_next = RX_START;
         RX_START: if (w_end) w_next = w_rx ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_end && r_bit == 3'd7) w_next = RX_STOP;
         RX_STOP:  if (w_end) w_next = RX_IDLE;
         default:  w_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= RX_IDLE;
      else r_state <= w_next;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync      <= 2'b11;
         r_prev      <= 1'b1;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_strobe    <= 1'b0;
         r_data      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_sync      <= {r_sync[0], i_rxd};
         r_prev      <= w_rx;
         r_strobe    <= w_stop_end & w_rx;
         r_frame_err <= w_stop_end & ~w_rx;
         if (w_stop_end && w_rx) r_data <= r_shift;
         // idle keeps the half-bit count preloaded so the start check lands mid-bit
         if (r_state == RX_IDLE) begin
            r_cnt <= i_baud >> 1;
            r_bit <= '0;
         end else if (w_end) begin
            r_cnt <= i_baud - 16'd1;
            if (r_state == RX_DATA) begin
               r_shift <= {w_rx, r_shift[7:1]};
               r_bit   <= r_bit + 3'd1;
            end
         end else begin
            r_cnt <= r_cnt - 16'd1;
         end
      end
   end

   assign o_rx_strobe = r_strobe;
   assign o_rx_data   = r_data;
   assign o_frame_err = r_frame_err;

endmodule

// File: rtl/cpu_uart.sv
// cpu_uart: CPU-bus responder exposing an 8N1 UART (STATUS, DATA, BAUD).
// Ports: i_clk, i_reset (async, active high), i_request/o_ack (fixed 1-cycle
//        handshake), i_address ([3:2] decoded), i_wdata, i_wmask (0 = read),
//        o_rdata (valid in the ack cycle, else 0), i_uart_rxd, o_uart_txd.
// Build option: CPU_UART_LOOPBACK_EN adds a R/W STATUS[8] loopback bit that
// feeds uart_txd back into the receiver.
module cpu_uart
   import cpu_uart_pkg::*;
#(
   parameter logic [15:0] BAUD_DIV_RESET = 16'd868
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_request,
   output logic        o_ack,
   input  logic [31:0] i_address,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wmask,
   output logic [31:0] o_rdata,
   input  logic        i_uart_rxd,
   output logic        o_uart_txd
);

   logic        r_ack;
   logic [31:0] r_rdata;
   logic [15:0] r_baud;
   logic [15:0] w_baud;
   logic [1:0]  w_idx;
   logic        w_req, w_wr, w_rd;
   logic        w_wr_status, w_wr_data, w_rd_data, w_wr_baud;
   logic [31:0] w_status, w_rd_val;
   logic        w_loop;

   tx_state_t   r_tx_state, w_tx_next;
   logic [15:0] r_tx_cnt;
   logic [2:0]  r_tx_bit;
   logic [7:0]  r_tx_shift, r_tx_hold;
   logic        r_tx_full, r_txd, w_tx_end, w_tx_load;

   logic        r_tx_drop, r_rx_valid, r_rx_overrun, r_rx_frame_err;
   logic [7:0]  r_rx_byte;
   logic        w_rx_in, w_rx_strobe, w_rx_frame_err;
   logic [7:0]  w_rx_data;
   logic        w_unused;

   assign w_unused = ^{i_address[31:4], i_address[1:0], i_wdata[31:16]};

   // a request overlapping an ack cannot be answered in one cycle, so drop it
   assign w_req       = i_request & ~r_ack;
   assign w_wr        = w_req & (|i_wmask);
   assign w_rd        = w_req & ~(|i_wmask);
   assign w_idx       = i_address[3:2];
   assign w_wr_status = w_wr && (w_idx == R_STATUS) && i_wmask[0];
   assign w_wr_data   = w_wr && (w_idx == R_DATA) && i_wmask[0];
   assign w_rd_data   = w_rd && (w_idx == R_DATA);
   assign w_wr_baud   = w_wr && (w_idx == R_BAUD);
   assign w_baud      = eff_baud(r_baud);

`ifdef CPU_UART_LOOPBACK_EN
   logic r_loop;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_loop <= 1'b0;
      else if (w_wr && (w_idx == R_STATUS) && i_wmask[1]) r_loop <= i_wdata[ST_LOOPBACK];
   end
   assign w_loop  = r_loop;
   assign w_rx_in = r_loop ? r_txd : i_uart_rxd;
`else
   assign w_loop  = 1'b0;
   assign w_rx_in = i_uart_rxd;
`endif

   always_comb begin
      w_status                  = '0;
      w_status[ST_TX_BUSY]      = (r_tx_state != T_IDLE);
      w_status[ST_TX_FULL]      = r_tx_full;
      w_status[ST_RX_VALID]     = r_rx_valid;
      w_status[ST_RX_OVERRUN]   = r_rx_overrun;
      w_status[ST_TX_DROP]      = r_tx_drop;
      w_status[ST_RX_FRAME_ERR] = r_rx_frame_err;
      w_status[ST_LOOPBACK]     = w_loop;
   end

   assign w_rd_val = (w_idx == R_STATUS) ? w_status :
                     (w_idx == R_DATA)   ? {24'h0, r_rx_byte} :
                     (w_idx == R_BAUD)   ? {16'h0, r_baud} : 32'h0;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_baud  <= BAUD_DIV_RESET;
      end else begin
         r_ack   <= w_req;
         r_rdata <= w_rd ? w_rd_val : 32'h0;
         if (w_wr_baud && i_wmask[0]) r_baud[7:0]  <= i_wdata[7:0];
         if (w_wr_baud && i_wmask[1]) r_baud[15:8] <= i_wdata[15:8];
      end
   end

   assign w_tx_end = (r_tx_cnt == 16'd0);

   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_load = 1'b0;
      case (r_tx_state)
         T_IDLE: if (r_tx_full) begin
            w_tx_next = T_START;
            w_tx_load = 1'b1;
         end
         T_START: if (w_tx_end) w_tx_next = T_DATA;
         T_DATA:  if (w_tx_end && r_tx_bit == 3'd7) w_tx_next = T_STOP;
         T_STOP: if (w_tx_end) begin
            w_tx_next = r_tx_full ? T_START : T_IDLE;
            w_tx_load = r_tx_full;
         end
         default: w_tx_next = T_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_tx_state <= T_IDLE;
      else r_tx_state <= w_tx_next;
   end

   // divider is re-read at every bit boundary so BAUD writes apply to the next bit
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_txd <= (w_tx_next == T_START) ? 1'b0 :
                  (w_tx_next == T_DATA)  ? ((r_tx_state == T_DATA && w_tx_end) ? r_tx_shift[1] : r_tx_shift[0]) :
                  1'b1;
         if (w_tx_load) begin
            r_tx_shift <= r_tx_hold;
            r_tx_bit   <= '0;
            r_tx_cnt   <= w_baud - 16'd1;
         end else if (r_tx_state != T_IDLE) begin
            r_tx_cnt <= w_tx_end ? w_baud - 16'd1 : r_tx_cnt - 16'd1;
            if (r_tx_state == T_DATA && w_tx_end) begin
               r_tx_shift <= r_tx_shift >> 1;
               r_tx_bit   <= r_tx_bit + 3'd1;
            end
         end
      end
   end

   // the holding register frees up in the same cycle the shifter takes it
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tx_hold <= '0;
         r_tx_full <= 1'b0;
         r_tx_drop <= 1'b0;
      end else begin
         if (w_wr_data && (!r_tx_full || w_tx_load)) begin
            r_tx_hold <= i_wdata[7:0];
            r_tx_full <= 1'b1;
         end else if (w_tx_load) begin
            r_tx_full <= 1'b0;
         end
         if (w_wr_data && r_tx_full && !w_tx_load) r_tx_drop <= 1'b1;
         else if (w_wr_status && i_wdata[ST_TX_DROP]) r_tx_drop <= 1'b0;
      end
   end

   cpu_uart_rx u_rx (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rxd       (w_rx_in),
      .i_baud      (w_baud),
      .o_rx_strobe (w_rx_strobe),
      .o_rx_data   (w_rx_data),
      .o_frame_err (w_rx_frame_err)
   );

   // a byte landing with a DATA read replaces the one being read: not an overrun
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_rx_byte      <= '0;
         r_rx_valid     <= 1'b0;
         r_rx_overrun   <= 1'b0;
         r_rx_frame_err <= 1'b0;
      end else begin
         if (w_rx_strobe) r_rx_byte <= w_rx_data;
         if (w_rx_strobe) r_rx_valid <= 1'b1;
         else if (w_rd_data) r_rx_valid <= 1'b0;
         if (w_rx_strobe && r_rx_valid && !w_rd_data) r_rx_overrun <= 1'b1;
         else if (w_wr_status && i_wdata[ST_RX_OVERRUN]) r_rx_overrun <= 1'b0;
         if (w_rx_frame_err) r_rx_frame_err <= 1'b1;
         else if (w_wr_status && i_wdata[ST_RX_FRAME_ERR]) r_rx_frame_err <= 1'b0;
      end
   end

   assign o_ack      = r_ack;
   assign o_rdata    = r_rdata;
   assign o_uart_txd = r_txd;

endmodule

// File: tb/tb_cpu_uart.sv
// tb_cpu_uart: directed bench for cpu_uart with a waveform-level reference model.
module tb_cpu_uart;

   logic        clk = 1'b0;
   logic        rst, req, rxd;
   logic [31:0] addr, wdata;
   logic [3:0]  wmask;
   logic        ack, txd;
   logic [31:0] rdata;
   logic        chk_en = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   logic        m_ack, m_txd, m_busy, m_full, m_drop;
   logic        m_rx_valid, m_overrun, m_ferr;
   logic [31:0] m_rdata;
   logic [7:0]  m_hold, m_rx_byte;
   logic [15:0] m_baud;
   bit          m_line[$];

   always #5 clk = ~clk;

   cpu_uart dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_request  (req),
      .o_ack      (ack),
      .i_address  (addr),
      .i_wdata    (wdata),
      .i_wmask    (wmask),
      .o_rdata    (rdata),
      .i_uart_rxd (rxd),
      .o_uart_txd (txd)
   );

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_line.delete();
      m_ack = 0; m_rdata = 0; m_txd = 1; m_busy = 0;
      m_full = 0; m_drop = 0; m_hold = 0;
      m_rx_valid = 0; m_overrun = 0; m_ferr = 0; m_rx_byte = 0;
      m_baud = 16'h0364;
   endfunction

   function automatic logic [31:0] m_status();
      return {26'h0, m_ferr, m_drop, m_overrun, m_rx_valid, m_full, m_busy};
   endfunction

   // expected txd is a per-clock list of line levels; a frame is queued whenever
   // the line list runs dry while a byte waits in the holding register
   function automatic void model_edge();
      logic rq, wr, rd;
      logic [1:0] idx;
      logic [31:0] rv;
      logic [7:0] sb;
      int b;
      rq = req && !m_ack;
      wr = rq && (wmask != 0);
      rd = rq && (wmask == 0);
      idx = addr[3:2];
      rv = 0;
      if (rd) rv = (idx == 0) ? m_status() : (idx == 1) ? {24'h0, m_rx_byte} : (idx == 2) ? {16'h0, m_baud} : 32'h0;
      if (m_line.size() == 0 && m_full) begin
         b = (m_baud < 2) ? 2 : int'(m_baud);
         sb = m_hold;
         m_full = 0;
         for (int k = 0; k < 10; k++)
            for (int j = 0; j < b; j++)
               m_line.push_back(k == 0 ? 1'b0 : k == 9 ? 1'b1 : sb[k-1]);
      end
      if (wr && idx == 1 && wmask[0]) begin
         if (!m_full) begin m_hold = wdata[7:0]; m_full = 1; end
         else m_drop = 1;
      end
      if (wr && idx == 0 && wmask[0]) begin
         if (wdata[3]) m_overrun = 0;
         if (wdata[4]) m_drop = 0;
         if (wdata[5]) m_ferr = 0;
      end
      if (wr && idx == 2 && wmask[0]) m_baud[7:0] = wdata[7:0];
      if (wr && idx == 2 && wmask[1]) m_baud[15:8] = wdata[15:8];
      if (rd && idx == 1) m_rx_valid = 0;
      if (m_line.size() > 0) begin m_txd = m_line.pop_front(); m_busy = 1; end
      else begin m_txd = 1; m_busy = 0; end
      m_ack = rq;
      m_rdata = rv;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("ack", {31'h0, ack}, {31'h0, m_ack});
         check("rdata", rdata, m_rdata);
         check("txd", {31'h0, txd}, {31'h0, m_txd});
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output logic [31:0] rv);
      addr = a; wdata = d; wmask = m; req = 1;
      tick();
      req = 0;
      check("ack_latency", {31'h0, ack}, 32'h1);
      rv = rdata;
      tick();
      addr = 0; wdata = 0; wmask = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] v;
      bus(a, d, m, v);
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus(a, 32'h0, 4'h0, v);
      check(nm, v, exp);
   endtask

   task automatic rx_send(input logic [7:0] b, input bit stop, input int bd);
      rxd = 0;
      repeat (bd) tick();
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (bd) tick();
      end
      rxd = stop;
      repeat (bd) tick();
      rxd = 1;
      repeat (2 * bd) tick();
      if (stop) begin
         if (m_rx_valid) m_overrun = 1;
         m_rx_valid = 1;
         m_rx_byte = b;
      end else begin
         m_ferr = 1;
      end
   endtask

   initial begin
      logic [9:0] s;
      rst = 1; req = 0; rxd = 1; addr = 0; wdata = 0; wmask = 0;
      model_reset();
      repeat (3) tick();
      rst = 0;
      chk_en = 1;
      tick();

      rd_chk("reset_status", 32'h0, 32'h0);
      rd_chk("reset_baud", 32'h8, 32'h364);
      check("reset_txd", {31'h0, txd}, 32'h1);
      wr(32'h8, 32'h12345678, 4'b0001);
      rd_chk("baud_lane0", 32'h8, 32'h378);
      wr(32'hC, 32'hFFFFFFFF, 4'hF);
      rd_chk("reg3_zero", 32'hC, 32'h0);

      wr(32'h8, 32'h4, 4'b0011);
      wr(32'h4, 32'hA5, 4'b0001);
      for (int i = 0; i < 10; i++) begin
         s[i] = txd;
         repeat (4) tick();
      end
      check("a5_bits", {22'h0, s}, 32'h34A);
      rd_chk("a5_idle_status", 32'h0, 32'h0);

      wr(32'h4, 32'h11, 4'b0001);
      wr(32'h4, 32'h22, 4'b0001);
      wr(32'h4, 32'h33, 4'b0001);
      rd_chk("b2b_status", 32'h0, 32'h13);
      wr(32'h0, 32'h10, 4'b0001);
      rd_chk("drop_cleared", 32'h0, 32'h03);
      repeat (100) tick();
      rd_chk("b2b_done", 32'h0, 32'h0);

      wr(32'h8, 32'h1, 4'b0011);
      rd_chk("baud_raw1", 32'h8, 32'h1);
      wr(32'h4, 32'h0F, 4'b0001);
      repeat (25) tick();

      wr(32'h8, 32'h8, 4'b0011);
      rx_send(8'h5A, 1, 8);
      rd_chk("rx_valid", 32'h0, 32'h04);
      rd_chk("rx_byte", 32'h4, 32'h5A);
      rd_chk("rx_cleared", 32'h0, 32'h00);
      rxd = 0;
      repeat (3) tick();
      rxd = 1;
      repeat (20) tick();
      rd_chk("glitch", 32'h0, 32'h00);

      rx_send(8'h3C, 1, 8);
      rx_send(8'hC3, 1, 8);
      rd_chk("overrun", 32'h0, 32'h0C);
      rx_send(8'h77, 0, 8);
      rd_chk("frame_err", 32'h0, 32'h2C);
      rd_chk("overrun_byte", 32'h4, 32'hC3);
      rd_chk("after_read", 32'h0, 32'h28);
      wr(32'h0, 32'h38, 4'b0001);
      rd_chk("flags_cleared", 32'h0, 32'h0);

      wr(32'h8, 32'h4, 4'b0011);
      wr(32'h4, 32'hA5, 4'b0001);
      repeat (17) tick();
      check("mid_bit3", {31'h0, txd}, 32'h0);
      #1;
      rst = 1;
      model_reset();
      #1;
      check("reset_txd_async", {31'h0, txd}, 32'h1);
      repeat (2) tick();
      rst = 0;
      tick();
      rd_chk("post_reset_status", 32'h0, 32'h0);
      rd_chk("post_reset_baud", 32'h8, 32'h364);
      check("post_reset_txd", {31'h0, txd}, 32'h1);
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_uart.md
Name: cpu_uart

Overview:
Bus responder on the CPU bus: the device end of the request/ack protocol driven by the CPU initiator.
- Exposes a 3-register 8N1 UART: STATUS, DATA, BAUD.
- Sits behind the address decoder; `request` arrives already qualified for this device.
- Drives `uart_txd` and samples `uart_rxd` at the FPGA pins.

Parameters:
- BAUD_DIV_RESET, 16'd868, reset value of BAUD (clocks per bit; 100 MHz / 115200).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- request  in  1  one-cycle pulse; address/wdata/wmask are stable from this cycle until ack
- ack  out  1  one-cycle completion pulse
- address  in  32  byte address; only [3:2] decoded
- wdata  in  32  write data
- wmask  in  4  byte-lane write strobes; 4'h0 = read, nonzero = write
- rdata  out  32  read data, valid in the ack cycle, otherwise 0
- uart_rxd  in  1  asynchronous serial input
- uart_txd  out  1  serial output, idle high

Behaviour:
- Reset (async, immediate): ack=0, rdata=0, uart_txd=1, all STATUS flags 0, BAUD=BAUD_DIV_RESET, TX/RX FSMs idle. Any frame in progress is aborted.
- Handshake: ack is registered exactly 1 cycle after request (fixed latency 1). A request arriving while ack=1 cannot occur; if it does, it is ignored.
- Register map, address[3:2]:
  - 0 STATUS: [0] tx_busy, [1] tx_full, [2] rx_valid, [3] rx_overrun, [4] tx_drop, [5] rx_frame_err. Reads return all 6 bits. Writing 1 to bits [5:3] (lane 0) clears them. Other bits are read-only.
  - 1 DATA: a write with wmask[0] pushes wdata[7:0] into the TX holding register. A read returns {24'h0, rx_byte} and clears rx_valid.
  - 2 BAUD: [15:0] divider, byte-lane masked. Stored values below 2 are used as 2.
  - 3: reads 0, writes ignored.
- TX path: one holding register plus a shift register.
  - FSM states: T_IDLE → T_START → T_DATA (8 bits, LSB first) → T_STOP → back to T_IDLE, or straight to T_START if holding is full.
  - Each state lasts BAUD clocks.
  - A DATA write while tx_full=1 is dropped and sets tx_drop.
  - If a write lands in the same cycle the shifter loads from holding, the new byte is accepted into holding.
- RX path: uart_rxd passes through a 2-flop synchroniser.
  - FSM states: R_IDLE → R_START → R_DATA → R_STOP.
  - On a falling edge in R_IDLE, a counter is loaded with BAUD/2 (floor). If the start bit is still 0 at mid-bit, continue; otherwise return to R_IDLE (glitch).
  - Bits are then sampled every BAUD clocks.
  - Stop bit=0: byte discarded, rx_frame_err set.
  - Valid byte with rx_valid already 1: byte overwrites rx_byte and rx_overrun is set.
  - Byte completing in the same cycle as a DATA read: the read returns the old byte, the new byte is stored, rx_valid stays 1, no overrun.
- BAUD written mid-frame takes effect at the next bit boundary.

Optional Feature:
- Macro CPU_UART_LOOPBACK_EN.
  - Defined: STATUS[8] is a R/W loopback bit, reset 0. When it is 1, the RX synchroniser input is uart_txd instead of uart_rxd, and uart_txd is still driven.
  - Undefined: STATUS[8] reads 0, writes are ignored, no mux is present.

Decomposition:
- Package cpu_uart_pkg holds:
  - register index enum: R_STATUS=0, R_DATA=1, R_BAUD=2
  - STATUS bit-position constants
  - TX and RX FSM state enums
- Sub-module cpu_uart_rx: synchroniser, RX FSM and bit counter. Outputs rx_strobe, rx_data[7:0] and frame_err; the top handles flags and the bus side.

Test Plan:
- Reset, then read STATUS and BAUD → ack exactly 1 cycle after each request; rdata=0x0 and 0x364; uart_txd=1.
- Write BAUD=4, then DATA=0xA5 → txd low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks; tx_busy is 1 for 40 clocks.
- Write DATA 0x11, 0x22, 0x33 back-to-back at BAUD=4 → 0x11 and 0x22 are sent, 0x33 is dropped, STATUS reads 0x13 (tx_busy|tx_full|tx_drop) right after the third write; writing 0x10 clears tx_drop.
- Drive rxd with 0x5A at BAUD=8 → rx_valid=1, DATA read returns 0x5A, then rx_valid=0; a 3-clock low glitch yields no byte.
- Send two RX bytes without reading → rx_overrun=1, DATA returns the second byte; stop bit forced 0 → rx_frame_err=1, rx_valid unchanged.
- Assert reset mid-TX frame (bit 3) → txd=1 in the same cycle; after release STATUS=0 and BAUD=0x364.
